// File: rtl/mul_issue_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mul_issue_if : requester, multiplier and response bundle for the shared   |
// | multiplier issue arbiter.                          Revision: 1.0          |
// +---------------------------------------------------------------------------+
interface mul_issue_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [63:0]        mul_res;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_data;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_res, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_res, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/mul_issue_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mul_issue_arbiter : round-robin, credit-gated issue of NREQ requesters    |
// | onto one non-stalling pipelined multiplier, results via in-order FIFO.    |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mul_issue_arbiter #(
  parameter int NREQ  = 4,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_issue_if.slave   bus
);
  localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cnt_w  = $clog2(DEPTH + 1);
  localparam int c_use_w  = $clog2(DEPTH + LAT + 1) + 1;

  logic [IDW-1:0]      r_rr_ptr;
  logic [LAT-1:0]      r_vld;
  logic [IDW-1:0]      r_id [LAT];
  logic [63:0]         r_mem_data [DEPTH];
  logic [IDW-1:0]      r_mem_id [DEPTH];
  logic [c_addr_w-1:0] r_wr_ptr;
  logic [c_addr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;

  logic [c_use_w-1:0]  w_inflight;
  logic                w_issue_ok;
  logic                w_found;
  logic                w_grant;
  logic                w_push;
  logic                w_pop;
  logic [IDW-1:0]      w_win;
  logic [31:0]         w_a;
  logic [31:0]         w_b;
  int                  w_idx;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + c_use_w'(r_vld[i]);
    end
  end

  // Pops in the current cycle are deliberately not credited: both terms are registered.
  assign w_issue_ok = (w_inflight + c_use_w'(r_count)) < c_use_w'(DEPTH);

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_a     = '0;
    w_b     = '0;
    w_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!w_found && bus.req_valid[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
        w_a     = bus.req_a[32*w_idx +: 32];
        w_b     = bus.req_b[32*w_idx +: 32];
      end
    end
  end

  // No grant may be visible while reset is held.
  assign w_grant = w_found & w_issue_ok & rst_n;

  always_comb begin
    bus.req_ready = '0;
    if (w_grant) begin
      bus.req_ready[w_win] = 1'b1;
    end
  end

  assign bus.mul_a = w_grant ? w_a : 32'd0;
  assign bus.mul_b = w_grant ? w_b : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_id[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_grant;
      r_id[0]  <= w_win;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  assign w_push = r_vld[LAT-1];
  assign w_pop  = (r_count != '0) & bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_addr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_addr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= bus.mul_res;
      r_mem_id[r_wr_ptr]   <= r_id[LAT-1];
    end
  end

  assign bus.rsp_valid = (r_count != '0);
  assign bus.rsp_id    = r_mem_id[r_rd_ptr];
  assign bus.rsp_data  = r_mem_data[r_rd_ptr];
  assign bus.busy      = (w_inflight != '0) | (r_count != '0);

  // The multiplier cannot stall, so a capture into a full FIFO would lose a result.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == c_cnt_w'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mul_issue_arbiter : scenario tasks plus a queue-based scoreboard of    |
// | grants, credits and in-order responses.            Revision: 1.0          |
// +---------------------------------------------------------------------------+
module tb_mul_issue_arbiter;
  localparam int NREQ  = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    data;
    int             rdy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mul_issue_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  mul_issue_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    return 64'(longint'($signed(a)) * longint'($signed(b)));
  endfunction

  // External pipelined multiplier: LAT register stages, result visible LAT cycles after issue.
  logic [63:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= smul(bus.mul_a, bus.mul_b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mul_res = pipe[LAT-1];

  // Scoreboard: outstanding count for credits, expected-response queue, rr pointer, fairness.
  exp_t            q[$];
  int              cyc = 0;
  int              m_ptr = 0;
  int              m_out = 0;
  int              issued = 0;
  int              wait_cnt [NREQ];
  logic [NREQ-1:0] last_hs = '0;

  initial begin
    int              win;
    int              j;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     ea, eb;
    logic            exp_rv;
    exp_t            e;
    for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      last_hs = '0;
      if (!rst_n) begin
        q.delete();
        m_ptr = 0;
        m_out = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        checks++;
        if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.mul_a !== 32'd0 || bus.mul_b !== 32'd0) begin
          errors++;
          $display("FAIL mon_reset_outputs: req_ready=%b rsp_valid=%b busy=%b mul_a=%h mul_b=%h, required all zero",
                   bus.req_ready, bus.rsp_valid, bus.busy, bus.mul_a, bus.mul_b);
        end
      end else begin
        win = -1;
        if (m_out < DEPTH) begin
          for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (win < 0 && bus.req_valid[j]) win = j;
          end
        end
        exp_rdy = '0;
        ea = '0;
        eb = '0;
        if (win >= 0) begin
          exp_rdy[win] = 1'b1;
          ea = bus.req_a[32*win +: 32];
          eb = bus.req_b[32*win +: 32];
        end
        checks++;
        if (bus.req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL mon_grant: cycle %0d req_ready=%b required %b", cyc, bus.req_ready, exp_rdy);
        end
        checks++;
        if (bus.mul_a !== ea || bus.mul_b !== eb) begin
          errors++;
          $display("FAIL mon_operands: cycle %0d mul_a/b=%h/%h required %h/%h", cyc, bus.mul_a, bus.mul_b, ea, eb);
        end
        exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
        checks++;
        if (bus.rsp_valid !== exp_rv) begin
          errors++;
          $display("FAIL mon_rsp_valid: cycle %0d rsp_valid=%b required %b", cyc, bus.rsp_valid, exp_rv);
        end
        if (exp_rv) begin
          checks++;
          if (bus.rsp_id !== q[0].id || bus.rsp_data !== q[0].data) begin
            errors++;
            $display("FAIL mon_rsp_data: cycle %0d id/data=%0d/%h required %0d/%h",
                     cyc, bus.rsp_id, bus.rsp_data, q[0].id, q[0].data);
          end
        end
        checks++;
        if (bus.busy !== (m_out != 0)) begin
          errors++;
          $display("FAIL mon_busy: cycle %0d busy=%b required %b", cyc, bus.busy, (m_out != 0));
        end
        for (int i = 0; i < NREQ; i++) begin
          if (!bus.req_valid[i] || i == win) begin
            wait_cnt[i] = 0;
          end else if (win >= 0) begin
            wait_cnt[i]++;
            checks++;
            if (wait_cnt[i] > NREQ - 1) begin
              errors++;
              $display("FAIL mon_fairness: requester %0d waited %0d grants, limit %0d", i, wait_cnt[i], NREQ - 1);
            end
          end
        end
        if (win >= 0) begin
          e.id   = IDW'(win);
          e.data = smul(ea, eb);
          e.rdy  = cyc + LAT + 1;
          q.push_back(e);
          m_ptr = (win + 1) % NREQ;
          m_out++;
          last_hs[win] = 1'b1;
          issued++;
        end
        if (exp_rv && bus.rsp_ready) begin
          void'(q.pop_front());
          m_out--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
      n++;
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 8)
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    bus.req_valid = '1;
    bus.req_a     = '1;
    bus.req_b     = '1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req_ready=%b rsp_valid=%b busy=%b required 0/0/0",
               bus.req_ready, bus.rsp_valid, bus.busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: req_ready=%b busy=%b required 0/0", bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_single();
    int lat = -1;
    tick();
    bus.req_valid    = 4'b0001;
    bus.req_a[31:0]  = 32'd7;
    bus.req_b[31:0]  = 32'hFFFF_FFFD;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: req_ready=%b required 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL single_latency: rsp_valid after %0d cycles, required 3", lat);
    end else begin
      checks++;
      if (bus.rsp_id !== 2'd0 || bus.rsp_data !== 64'hFFFF_FFFF_FFFF_FFEB) begin
        errors++;
        $display("FAIL single_result: id/data=%0d/%h required 0/ffffffffffffffeb", bus.rsp_id, bus.rsp_data);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g;
    int              n;
    tick();
    bus.req_valid = '1;
    bus.req_a     = {$urandom, $urandom, $urandom, $urandom};
    bus.req_b     = {$urandom, $urandom, $urandom, $urandom};
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_g = '0;
      exp_g[(1 + c) % NREQ] = 1'b1;
      checks++;
      if (bus.req_ready !== exp_g) begin
        errors++;
        $display("FAIL rr_grant: step %0d req_ready=%b required %b", c, bus.req_ready, exp_g);
      end
      if (c >= LAT + 1) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'((1 + c - LAT - 1) % NREQ)) begin
          errors++;
          $display("FAIL rr_rsp_stream: step %0d rsp_valid=%b id=%0d required 1/%0d",
                   c, bus.rsp_valid, bus.rsp_id, (1 + c - LAT - 1) % NREQ);
        end
      end
      tick();
      bus.req_a = {$urandom, $urandom, $urandom, $urandom};
      bus.req_b = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.req_valid = '0;
    wait_idle(n);
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL rr_drain: busy still high after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_credit();
    int grants = 0;
    int n;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.req_ready[2] === 1'b1) grants++;
      tick();
      bus.req_a[64 +: 32] = $urandom;
      bus.req_b[64 +: 32] = $urandom;
    end
    checks++;
    if (grants != DEPTH) begin
      errors++;
      $display("FAIL credit_fill: %0d grants with rsp_ready low, required %0d", grants, DEPTH);
    end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0) begin
      errors++;
      $display("FAIL credit_stall: req_ready=%b required 0000", bus.req_ready);
    end
    tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL credit_same_cycle_pop: req_ready=%b rsp_valid=%b required 0000/1", bus.req_ready, bus.rsp_valid);
    end
    tick();
    bus.rsp_ready = 1'b0;
    grants = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.req_ready[2] === 1'b1) grants++;
      tick();
    end
    checks++;
    if (grants != 1) begin
      errors++;
      $display("FAIL credit_refill: %0d grants after one pop, required 1", grants);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle(n);
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL credit_drain: busy still high after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_extremes();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [63:0] tp [4];
    logic        seen;
    ta[0] = 32'h8000_0000; tb[0] = 32'h8000_0000; tp[0] = 64'h4000_0000_0000_0000;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'h0000_0001; tp[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    ta[2] = 32'h7FFF_FFFF; tb[2] = 32'h7FFF_FFFF; tp[2] = 64'h3FFF_FFFF_0000_0001;
    ta[3] = 32'h8000_0000; tb[3] = 32'h7FFF_FFFF; tp[3] = 64'hC000_0000_8000_0000;
    bus.rsp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      bus.req_valid       = 4'b0010;
      bus.req_a[32 +: 32] = ta[t];
      bus.req_b[32 +: 32] = tb[t];
      tick();
      bus.req_valid = '0;
      seen = 1'b0;
      for (int n = 0; n < 8 && !seen; n++) begin
        @(negedge clk);
        if (bus.rsp_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || bus.rsp_data !== tp[t] || bus.rsp_id !== 2'd1) begin
        errors++;
        $display("FAIL extreme_%0d: valid=%b id=%0d data=%h required 1/1/%h", t, seen, bus.rsp_id, bus.rsp_data, tp[t]);
      end
    end
  endtask

  task automatic test_reset_midop();
    int n;
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tick();
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL midop_loaded: busy=%b rsp_valid=%b required 1/1", bus.busy, bus.rsp_valid);
    end
    bus.req_valid = '1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== '0) begin
      errors++;
      $display("FAIL midop_reset_immediate: rsp_valid=%b busy=%b req_ready=%b required 0/0/0000",
               bus.rsp_valid, bus.busy, bus.req_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midop_first_grant: req_ready=%b required 0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    wait_idle(n);
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL midop_drain: busy still high after %0d cycles, required idle", n);
    end
  endtask

  task automatic test_random();
    int start = issued;
    int ncyc  = 0;
    int n;
    while ((issued - start) < 10000 && ncyc < 40000) begin
      tick();
      ncyc++;
      for (int i = 0; i < NREQ; i++) begin
        if (last_hs[i] || !bus.req_valid[i]) begin
          bus.req_valid[i]       = ($urandom % 4) != 0;
          bus.req_a[32*i +: 32]  = rnd_op();
          bus.req_b[32*i +: 32]  = rnd_op();
        end else if (($urandom % 16) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom % 10) < 7;
    end
    checks++;
    if ((issued - start) < 10000) begin
      errors++;
      $display("FAIL random_ops: %0d ops issued in %0d cycles, required 10000", issued - start, ncyc);
    end
    tick();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    wait_idle(n);
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL random_drain: busy still high after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_extremes();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "simulation time limit");
  end
endmodule
`default_nettype wire
